// File: rtl/vga_pic_bounce.sv
// Bouncing-picture pixel source between vga_ctrl and a single-port image ROM.
// Moves the picture once per FRAME_DIV frames at end of frame and streams ROM words for covered pixels.
module vga_pic_bounce #(
    parameter int          H_VALID   = 640,
    parameter int          V_VALID   = 480,
    parameter int          H_PIC     = 100,
    parameter int          V_PIC     = 100,
    parameter int          PIC_SIZE  = 10000,
    parameter int          ADDR_W    = 14,
    parameter int          X_STEP    = 1,
    parameter int          Y_STEP    = 1,
    parameter int          FRAME_DIV = 1,
    parameter int          ROM_LAT   = 1,
    parameter logic [15:0] BG_COLOR  = 16'hFFFF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [15:0]       rom_data,
    output logic [15:0]       pix_data,
    output logic              hit_edge
);

    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [10:0]       XMAX      = 11'(H_VALID - H_PIC);
    localparam logic [10:0]       YMAX      = 11'(V_VALID - V_PIC);
    localparam logic [10:0]       H_PIC_W   = 11'(H_PIC);
    localparam logic [10:0]       V_PIC_W   = 11'(V_PIC);
    localparam logic [10:0]       X_STEP_W  = 11'(X_STEP);
    localparam logic [10:0]       Y_STEP_W  = 11'(Y_STEP);
    localparam logic [9:0]        X_LAST    = 10'(H_VALID - 1);
    localparam logic [9:0]        Y_LAST    = 10'(V_VALID - 1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAME_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIC_SIZE - 1);

    logic [10:0]       x_pos;
    logic [10:0]       y_pos;
    logic              dir_x;
    logic              dir_y;
    logic [FC_W-1:0]   frame_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ROM_LAT:0]  in_pic_d;
    logic [ROM_LAT:0]  valid_d;

    logic [10:0] px;
    logic [10:0] py;
    logic        pix_valid;
    logic        in_pic;
    logic        eof;
    logic        update;

    logic [10:0] x_nxt;
    logic [10:0] y_nxt;
    logic        dir_x_nxt;
    logic        dir_y_nxt;
    logic        x_hit;
    logic        y_hit;

    // Comparisons run in 11 bits so x_pos + H_PIC never wraps against the 10-bit pixel coordinate.
    assign px        = {1'b0, pix_x};
    assign py        = {1'b0, pix_y};
    assign pix_valid = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);
    assign in_pic    = pix_valid
                       && (px >= x_pos) && (px < x_pos + H_PIC_W)
                       && (py >= y_pos) && (py < y_pos + V_PIC_W);
    assign eof       = (pix_x == X_LAST) && (pix_y == Y_LAST);
    assign update    = eof && run && (frame_cnt == FC_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt <= '0;
        end else if (eof) begin
            if (!run || frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // A step that would reach or pass an edge lands exactly on it and reverses in the same update.
    always_comb begin
        x_nxt     = x_pos;
        dir_x_nxt = dir_x;
        x_hit     = 1'b0;
        if (dir_x) begin
            if (x_pos + X_STEP_W >= XMAX) begin
                x_nxt     = XMAX;
                dir_x_nxt = 1'b0;
                x_hit     = 1'b1;
            end else begin
                x_nxt = x_pos + X_STEP_W;
            end
        end else begin
            if (x_pos <= X_STEP_W) begin
                x_nxt     = '0;
                dir_x_nxt = 1'b1;
                x_hit     = 1'b1;
            end else begin
                x_nxt = x_pos - X_STEP_W;
            end
        end

        y_nxt     = y_pos;
        dir_y_nxt = dir_y;
        y_hit     = 1'b0;
        if (dir_y) begin
            if (y_pos + Y_STEP_W >= YMAX) begin
                y_nxt     = YMAX;
                dir_y_nxt = 1'b0;
                y_hit     = 1'b1;
            end else begin
                y_nxt = y_pos + Y_STEP_W;
            end
        end else begin
            if (y_pos <= Y_STEP_W) begin
                y_nxt     = '0;
                dir_y_nxt = 1'b1;
                y_hit     = 1'b1;
            end else begin
                y_nxt = y_pos - Y_STEP_W;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_pos    <= '0;
            y_pos    <= '0;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            hit_edge <= 1'b0;
        end else begin
            hit_edge <= update && (x_hit || y_hit);
            if (update) begin
                x_pos <= x_nxt;
                y_pos <= y_nxt;
                dir_x <= dir_x_nxt;
                dir_y <= dir_y_nxt;
            end
        end
    end

    // rom_addr carries the word for the pixel seen last cycle; addr_cnt is the next word to fetch.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rom_addr  <= '0;
            rom_rd_en <= 1'b0;
            addr_cnt  <= '0;
        end else begin
            rom_rd_en <= in_pic;
            if (in_pic) begin
                rom_addr <= addr_cnt;
            end else if (eof) begin
                rom_addr <= '0;
            end
            if (eof) begin
                addr_cnt <= '0;
            end else if (in_pic) begin
                addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_pic_d <= '0;
            valid_d  <= '0;
            pix_data <= '0;
        end else begin
            in_pic_d <= {in_pic_d[ROM_LAT-1:0], in_pic};
            valid_d  <= {valid_d[ROM_LAT-1:0], pix_valid};
            if (in_pic_d[ROM_LAT]) begin
                pix_data <= rom_data;
            end else if (valid_d[ROM_LAT]) begin
                pix_data <= BG_COLOR;
            end else begin
                pix_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Self-checking bench for vga_pic_bounce: a raster/bounce reference model checks every cycle,
// and a table of frame milestones checks edges, clamping and the frame divider.
module tb_vga_pic_bounce;

    localparam int          H_VALID  = 60;
    localparam int          V_VALID  = 50;
    localparam int          H_PIC    = 10;
    localparam int          V_PIC    = 10;
    localparam int          XMAX     = H_VALID - H_PIC;
    localparam int          YMAX     = V_VALID - V_PIC;
    localparam logic [15:0] BG       = 16'hFFFF;
    localparam logic [9:0]  BLANK    = 10'h3FF;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        run;

    logic [6:0]  rom_addr;
    logic        rom_rd_en;
    logic [15:0] rom_data;
    logic [15:0] pix_data;
    logic        hit_edge;

    logic [6:0]  rom_addr_b;
    logic        rom_rd_en_b;
    logic [15:0] rom_data_b;
    logic [15:0] pix_data_b;
    logic        hit_edge_b;

    vga_pic_bounce #(
        .H_VALID(H_VALID), .V_VALID(V_VALID), .H_PIC(H_PIC), .V_PIC(V_PIC),
        .PIC_SIZE(100), .ADDR_W(7), .X_STEP(1), .Y_STEP(1),
        .FRAME_DIV(1), .ROM_LAT(1), .BG_COLOR(BG)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .run(run),
        .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
        .pix_data(pix_data), .hit_edge(hit_edge)
    );

    // Second instance exercises overshoot clamping and the frame divider on the same raster.
    vga_pic_bounce #(
        .H_VALID(H_VALID), .V_VALID(V_VALID), .H_PIC(H_PIC), .V_PIC(V_PIC),
        .PIC_SIZE(100), .ADDR_W(7), .X_STEP(3), .Y_STEP(1),
        .FRAME_DIV(4), .ROM_LAT(1), .BG_COLOR(BG)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .run(run),
        .rom_addr(rom_addr_b), .rom_rd_en(rom_rd_en_b), .rom_data(rom_data_b),
        .pix_data(pix_data_b), .hit_edge(hit_edge_b)
    );

    always #5 sys_clk = ~sys_clk;

    // ROM content equals its address, one cycle of read latency.
    always @(posedge sys_clk) begin
        rom_data   <= 16'(rom_addr);
        rom_data_b <= 16'(rom_addr_b);
    end

    typedef struct {
        bit          chk;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        int frames;
        int x;
        int y;
        bit dx;
        bit dy;
        bit hit;
        int xb;
        bit hitb;
    } edge_vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_upd;
    int   mx;
    int   my;
    bit   exp_hit;
    bit   exp_rden;
    bit   have_rden;
    exp_t pq[$];
    edge_vec_t tbl[11];

    // A step-1 bounce over [0,m] is a triangle wave of period 2m in the update count.
    function automatic int fold(input int n, input int m);
        int r;
        r = n % (2 * m);
        return (r <= m) ? r : 2 * m - r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [9:0] px, input logic [9:0] py, input bit fast);
        exp_t e;
        bit   valid;
        bit   inp;
        int   nx;
        int   ny;
        @(posedge sys_clk);
        #1;
        if (have_rden) check_output("rom_rd_en", rom_rd_en, exp_rden);
        check_output("hit_edge", hit_edge, exp_hit);
        if (pq.size() == 3) begin
            e = pq.pop_front();
            if (e.chk) check_output("pix_data", pix_data, e.val);
        end
        pix_x = px;
        pix_y = py;
        valid = (px != BLANK) && (py != BLANK);
        inp   = valid && int'(px) >= mx && int'(px) < mx + H_PIC
                      && int'(py) >= my && int'(py) < my + V_PIC;
        e.chk = !(fast && inp);
        if (inp)        e.val = 16'((int'(py) - my) * H_PIC + (int'(px) - mx));
        else if (valid) e.val = BG;
        else            e.val = 16'h0000;
        pq.push_back(e);
        exp_rden  = inp;
        have_rden = 1'b1;
        exp_hit   = 1'b0;
        if (int'(px) == H_VALID - 1 && int'(py) == V_VALID - 1 && run) begin
            n_upd++;
            nx      = fold(n_upd, XMAX);
            ny      = fold(n_upd, YMAX);
            exp_hit = (nx == 0) || (nx == XMAX) || (ny == 0) || (ny == YMAX);
            mx      = nx;
            my      = ny;
        end
    endtask

    // Both frame tasks return in the cycle right after end of frame.
    task automatic full_frame(input bit random_run);
        repeat ($urandom_range(3, 8)) apply_stimulus(BLANK, BLANK, 1'b0);
        for (int y = 0; y < V_VALID; y++) begin
            if (random_run) run = 1'($urandom_range(0, 1));
            for (int x = 0; x < H_VALID; x++) apply_stimulus(10'(x), 10'(y), 1'b0);
            if (y < V_VALID - 1) repeat ($urandom_range(2, 5)) apply_stimulus(BLANK, BLANK, 1'b0);
        end
        apply_stimulus(BLANK, BLANK, 1'b0);
    endtask

    task automatic fast_frame();
        repeat (2) apply_stimulus(BLANK, BLANK, 1'b1);
        apply_stimulus(10'(H_VALID - 1), 10'(V_VALID - 1), 1'b1);
        apply_stimulus(BLANK, BLANK, 1'b1);
    endtask

    initial begin
        int f;

        tbl[0]  = '{1,   1,  1,  1'b1, 1'b1, 1'b0, 0,  1'b0};
        tbl[1]  = '{4,   4,  4,  1'b1, 1'b1, 1'b0, 3,  1'b0};
        tbl[2]  = '{40,  40, 40, 1'b1, 1'b0, 1'b1, 30, 1'b0};
        tbl[3]  = '{41,  41, 39, 1'b1, 1'b0, 1'b0, 30, 1'b0};
        tbl[4]  = '{50,  50, 30, 1'b0, 1'b0, 1'b1, 36, 1'b0};
        tbl[5]  = '{51,  49, 29, 1'b0, 1'b0, 1'b0, 36, 1'b0};
        tbl[6]  = '{64,  36, 16, 1'b0, 1'b0, 1'b0, 48, 1'b0};
        tbl[7]  = '{68,  32, 12, 1'b0, 1'b0, 1'b0, 50, 1'b1};
        tbl[8]  = '{72,  28, 8,  1'b0, 1'b0, 1'b0, 47, 1'b0};
        tbl[9]  = '{136, 36, 24, 1'b1, 1'b0, 1'b0, 0,  1'b1};
        tbl[10] = '{200, 0,  40, 1'b1, 1'b0, 1'b1, 48, 1'b0};

        n_upd = 0; mx = 0; my = 0;
        exp_hit = 1'b0; exp_rden = 1'b0; have_rden = 1'b0;
        sys_rst_n = 1'b0;
        pix_x = BLANK;
        pix_y = BLANK;
        run   = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_output("reset rom_addr", rom_addr, 0);
        check_output("reset rom_rd_en", rom_rd_en, 0);
        check_output("reset pix_data", pix_data, 0);
        check_output("reset hit_edge", hit_edge, 0);
        check_output("reset x_pos", dut.x_pos, 0);
        check_output("reset dir_x", dut.dir_x, 1);
        sys_rst_n = 1'b1;

        // First two frames at (0,0) and (1,1)
        full_frame(1'b0);
        check_output("rom_addr after eof", rom_addr, 0);
        check_output("x_pos after frame 0", dut.x_pos, 1);
        check_output("y_pos after frame 0", dut.y_pos, 1);
        full_frame(1'b0);

        // Pause for three frames
        run = 1'b0;
        repeat (3) full_frame(1'b0);
        check_output("paused x_pos", dut.x_pos, 2);
        check_output("paused y_pos", dut.y_pos, 2);
        check_output("paused frame_cnt_b", dut_b.frame_cnt, 0);

        // Random run toggling mid-frame; only the value at end of frame matters
        repeat (4) full_frame(1'b1);
        run = 1'b1;
        check_output("random x_pos", dut.x_pos, mx);
        check_output("random y_pos", dut.y_pos, my);

        // Reset in the middle of a picture line at (20,20)
        while (n_upd < 20) fast_frame();
        repeat (4) apply_stimulus(BLANK, BLANK, 1'b0);
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < H_VALID; x++) apply_stimulus(10'(x), 10'(y), 1'b0);
            repeat (3) apply_stimulus(BLANK, BLANK, 1'b0);
        end
        for (int x = 0; x <= 26; x++) apply_stimulus(10'(x), 10'd20, 1'b0);
        check_output("pre-reset rom_rd_en", rom_rd_en, 1);
        check_output("pre-reset rom_addr", rom_addr, 5);
        sys_rst_n = 1'b0;
        #1;
        check_output("async rom_addr", rom_addr, 0);
        check_output("async rom_rd_en", rom_rd_en, 0);
        check_output("async pix_data", pix_data, 0);
        check_output("async x_pos", dut.x_pos, 0);
        check_output("async y_pos", dut.y_pos, 0);
        pix_x = BLANK;
        pix_y = BLANK;
        pq.delete();
        have_rden = 1'b0;
        exp_hit   = 1'b0;
        n_upd = 0; mx = 0; my = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Milestones: first frame full from (0,0), the rest as short eof-only frames
        full_frame(1'b0);
        f = 1;
        for (int i = 0; i < 11; i++) begin
            while (f < tbl[i].frames) begin
                fast_frame();
                f++;
            end
            check_output($sformatf("f%0d x_pos", f), dut.x_pos, tbl[i].x);
            check_output($sformatf("f%0d y_pos", f), dut.y_pos, tbl[i].y);
            check_output($sformatf("f%0d dir_x", f), dut.dir_x, tbl[i].dx);
            check_output($sformatf("f%0d dir_y", f), dut.dir_y, tbl[i].dy);
            check_output($sformatf("f%0d hit_edge", f), hit_edge, tbl[i].hit);
            check_output($sformatf("f%0d x_pos_b", f), dut_b.x_pos, tbl[i].xb);
            check_output($sformatf("f%0d hit_edge_b", f), hit_edge_b, tbl[i].hitb);
        end
        repeat (4) apply_stimulus(BLANK, BLANK, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
